lcd_spi_rx_decoder: RTL and testbench
=====================================

// Module: lcd_spi_rx_decoder
// PURPOSE
//  Receive end of the 4-wire LCD SPI link (cs_n, sclk, mosi, dc, rst_n) that spi_lcd drives.
//  Decodes the ST7735-style command stream (CASET/RASET/RAMWR/SWRESET) into pixel writes {x,y,rgb565}.
//  Sits in the bench/mirror path: feeds a frame-capture memory or a VGA mirror of the panel.
// PARAMETERS
//  LCD_W      132    panel width; pixels with x >= LCD_W are suppressed
//  LCD_H      162    panel height; pixels with y >= LCD_H are suppressed
// PORTS
//  clk            in   1   system clock; lcd_clk_in must be <= clk/4 (each phase >= 2 clk)
//  rst            in   1   synchronous reset, active-high
//  lcd_rst_n_in   in   1   panel reset from link; low (after sync) = soft reset of decoder state
//  lcd_cs_n_in    in   1   chip select, active-low
//  lcd_clk_in     in   1   SPI clock; data sampled on rising edge
//  lcd_data_in    in   1   SPI data, MSB first
//  lcd_dc_in      in   1   0 = command byte, 1 = data byte; sampled with bit 0 of the byte
//  cmd_valid      out  1   1-cycle pulse: a command byte was received
//  cmd_code       out  8   last command byte; holds between pulses
//  pix_valid      out  1   1-cycle pulse: in-panel pixel written
//  pix_x          out  8   pixel column
//  pix_y          out  8   pixel row
//  pix_data       out  16  RGB565, first byte = [15:8]
//  frame_done     out  1   1-cycle pulse, coincident with the write to window (XE,YE)
// BEHAVIOUR
//  Reset (rst or synced lcd_rst_n_in=0): all outputs 0, cmd_code=8'h00, window XS=0 XE=LCD_W-1 YS=0 YE=LCD_H-1, cur cmd=NONE.
//  Front end: lcd_cs_n/clk/data/dc pass through a 2-FF synchronizer. Rising edge = s2 & ~s3.
//   - On an edge with cs_n=0: shift data in and increment bit_cnt (3 bit).
//   - On the 8th bit: byte_vld is registered together with dc.
//   - byte_vld rises 3 clk after the first clk edge that samples the raw sclk rise; pix_valid/cmd_valid rise 1 clk after byte_vld.
//  cs_n high: bit_cnt cleared, partial byte discarded. Command context (cur cmd, arg idx, pending pixel hi byte) is retained across cs_n.
//  Decoder FSM states: IDLE, ARG_CASET, ARG_RASET, RAMWR_HI, RAMWR_LO, IGNORE.
//   - Any dc=0 byte: cmd_valid pulse and cmd_code updated. Any partial arg/pixel is aborted, then:
//       8'h2A -> ARG_CASET, arg_idx=0
//       8'h2B -> ARG_RASET, arg_idx=0
//       8'h2C -> x=XS, y=YS, RAMWR_HI
//       8'h01 -> window to reset defaults, IDLE
//       other -> IGNORE
//   - ARG_CASET/RASET take 4 data bytes: [0]=S hi (ignored), [1]=S lo, [2]=E hi (ignored), [3]=E lo.
//       Window updates after byte 3; then IDLE. Extra data bytes go to IGNORE.
//       If E < S: latched E = S (single column/row).
//   - RAMWR_HI: latch hi byte -> RAMWR_LO. RAMWR_LO: form pixel -> RAMWR_HI.
//       Pixel pulse only when x < LCD_W and y < LCD_H; the address advances regardless.
//   - Address advance: x==XE ? (x=XS, y = (y==YE) ? YS : y+1) : x+1.
//       frame_done pulses when the written pixel is (XE,YE) (also if suppressed, pix_valid=0).
//   - IGNORE/IDLE: data bytes are dropped silently.
//   - Window change mid-RAMWR takes effect only at the next RAMWR.
//  Simultaneous rst and byte_vld: rst wins, byte lost.
//  No backpressure: the sink must accept 1 pixel per pix_valid.
// STRUCTURE
//  Shared package lcd_pkg: LCD_W/LCD_H defaults, CMD_SWRESET=8'h01, CMD_CASET=8'h2A, CMD_RASET=8'h2B,
//   CMD_RAMWR=8'h2C, decoder state encoding.
//  Sub-module lcd_spi_byte_rx: synchronizers, edge detect, shift register, bit_cnt -> {byte_vld, byte, dc}.
//  Top holds the command FSM, window registers and address counters.
// TESTING (bench BFM drives sclk = clk/8, MSB first)
//  1 After rst: cmd 2A, data 00 05 00 07; cmd 2B, data 00 0A 00 0B; cmd 2C; data 4 px F8 00 07 E0 00 1F FF FF
//     -> pix (5,10)=F800, (6,10)=07E0, (7,10)=001F, (5,11)=FFFF; no frame_done.
//  2 Continue 2 px in same window -> (6,11), (7,11); frame_done with (7,11); next px lands at (5,10).
//  3 CASET 00 80 00 85, RASET 0,0,0,0, RAMWR, 6 px
//     -> pix_valid only for x=128..131; x=132,133 suppressed; frame_done on the 6th.
//  4 cs_n raised after 5 bits of a data byte, then a full byte AB
//     -> partial dropped; AB is taken as the hi byte; no spurious pix_valid.
//  5 RAMWR, hi byte 12, then cmd 2C, then 34 56
//     -> cmd_valid twice; single pixel 3456 at (XS,YS).
//  6 lcd_rst_n_in low for 4 clk mid-RAMWR -> outputs 0, window defaults; following RAMWR px at (0,0).

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, command codes and types for the LCD SPI receive path.
package lcd_pkg;

    localparam int unsigned LCD_W_DEF = 132;
    localparam int unsigned LCD_H_DEF = 162;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned COORD_W   = 8;
    localparam int unsigned PIX_W     = 16;

    localparam logic [BYTE_W-1:0] CMD_SWRESET = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_CASET   = 8'h2A;
    localparam logic [BYTE_W-1:0] CMD_RASET   = 8'h2B;
    localparam logic [BYTE_W-1:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARG_CASET = 3'd1,
        ST_ARG_RASET = 3'd2,
        ST_RAMWR_HI  = 3'd3,
        ST_RAMWR_LO  = 3'd4,
        ST_IGNORE    = 3'd5
    } dec_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [PIX_W-1:0]   rgb;
    } pix_t;

    typedef struct packed {
        logic [COORD_W-1:0] xs;
        logic [COORD_W-1:0] xe;
        logic [COORD_W-1:0] ys;
        logic [COORD_W-1:0] ye;
    } win_t;

    // A window end below its start collapses to a single column/row.
    function automatic logic [COORD_W-1:0] clamp_end(input logic [COORD_W-1:0] s,
                                                     input logic [COORD_W-1:0] e);
        return (e < s) ? s : e;
    endfunction

endpackage

// File: rtl/lcd_spi_rx_decoder_if.sv
// LCD link pins plus decoded command/pixel stream.
interface lcd_spi_rx_decoder_if;
    import lcd_pkg::*;

    logic                lcd_rst_n_in;
    logic                lcd_cs_n_in;
    logic                lcd_clk_in;
    logic                lcd_data_in;
    logic                lcd_dc_in;

    logic                cmd_valid;
    logic [BYTE_W-1:0]   cmd_code;
    logic                pix_valid;
    logic [COORD_W-1:0]  pix_x;
    logic [COORD_W-1:0]  pix_y;
    logic [PIX_W-1:0]    pix_data;
    logic                frame_done;

    // Link driver / pixel sink side
    modport master (
        output lcd_rst_n_in, lcd_cs_n_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
        input  cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data, frame_done
    );

    // Decoder side
    modport slave (
        input  lcd_rst_n_in, lcd_cs_n_in, lcd_clk_in, lcd_data_in, lcd_dc_in,
        output cmd_valid, cmd_code, pix_valid, pix_x, pix_y, pix_data, frame_done
    );

endinterface

// File: rtl/lcd_spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizers, sclk rise detect, shift register.
module lcd_spi_byte_rx
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n_i,
    input  logic              sclk_i,
    input  logic              data_i,
    input  logic              dc_i,
    input  logic              rst_n_i,
    output logic              byte_vld_o,
    output logic [BYTE_W-1:0] byte_o,
    output logic              dc_o,
    output logic              soft_rst_o
);

    logic [2:0] sclk_sync_q;
    logic [1:0] cs_sync_q;
    logic [1:0] data_sync_q;
    logic [1:0] dc_sync_q;
    logic [1:0] srst_sync_q;

    logic rise_q;
    logic cs_p_q;
    logic data_p_q;
    logic dc_p_q;

    logic [BYTE_W-2:0] shift_q;
    logic [2:0]        bit_cnt_q;
    logic              byte_vld_q;
    logic [BYTE_W-1:0] byte_q;
    logic              dc_q;

    // Two-stage synchronizers, then one stage aligning data/dc/cs with the detected rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 2'b11;
            data_sync_q <= 2'b00;
            dc_sync_q   <= 2'b00;
            srst_sync_q <= 2'b00;
            rise_q      <= 1'b0;
            cs_p_q      <= 1'b1;
            data_p_q    <= 1'b0;
            dc_p_q      <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[0], cs_n_i};
            data_sync_q <= {data_sync_q[0], data_i};
            dc_sync_q   <= {dc_sync_q[0], dc_i};
            srst_sync_q <= {srst_sync_q[0], ~rst_n_i};
            rise_q      <= sclk_sync_q[1] & ~sclk_sync_q[2];
            cs_p_q      <= cs_sync_q[1];
            data_p_q    <= data_sync_q[1];
            dc_p_q      <= dc_sync_q[1];
        end
    end

    // Byte assembly; cs_n high discards any partial byte.
    always_ff @(posedge clk) begin
        if (rst || srst_sync_q[1]) begin
            shift_q    <= '0;
            bit_cnt_q  <= 3'd0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            dc_q       <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            if (cs_p_q) begin
                bit_cnt_q <= 3'd0;
            end else if (rise_q) begin
                shift_q   <= {shift_q[BYTE_W-3:0], data_p_q};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_vld_q <= 1'b1;
                    byte_q     <= {shift_q, data_p_q};
                    dc_q       <= dc_p_q;
                end
            end
        end
    end

    assign byte_vld_o = byte_vld_q;
    assign byte_o     = byte_q;
    assign dc_o       = dc_q;
    assign soft_rst_o = srst_sync_q[1];

endmodule

// File: rtl/lcd_spi_rx_decoder.sv
// ST7735-style command decoder: turns the LCD SPI byte stream into pixel writes.
module lcd_spi_rx_decoder
    import lcd_pkg::*;
#(
    parameter int unsigned LCD_W = LCD_W_DEF,
    parameter int unsigned LCD_H = LCD_H_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_spi_rx_decoder_if.slave  bus
);

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(LCD_W);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(LCD_H);
    localparam win_t WIN_DEF = '{xs: '0, xe: COORD_W'(LCD_W - 1), ys: '0, ye: COORD_W'(LCD_H - 1)};

    logic              byte_vld;
    logic [BYTE_W-1:0] rx_byte;
    logic              rx_dc;
    logic              soft_rst;
    logic              srst;

    lcd_spi_byte_rx u_byte_rx (
        .clk        (clk),
        .rst        (rst),
        .cs_n_i     (bus.lcd_cs_n_in),
        .sclk_i     (bus.lcd_clk_in),
        .data_i     (bus.lcd_data_in),
        .dc_i       (bus.lcd_dc_in),
        .rst_n_i    (bus.lcd_rst_n_in),
        .byte_vld_o (byte_vld),
        .byte_o     (rx_byte),
        .dc_o       (rx_dc),
        .soft_rst_o (soft_rst)
    );

    assign srst = rst | soft_rst;

    dec_state_e         state_q, state_d;
    logic [1:0]         arg_idx_q, arg_idx_d;
    logic [COORD_W-1:0] arg_lo_q, arg_lo_d;
    win_t               win_q, win_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [BYTE_W-1:0]  hi_q, hi_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [BYTE_W-1:0]  cmd_code_q, cmd_code_d;
    logic               pix_valid_q, pix_valid_d;
    pix_t               pix_q, pix_d;
    logic               frame_done_q, frame_done_d;

    // State, window, address and output registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            arg_idx_q    <= 2'd0;
            arg_lo_q     <= '0;
            win_q        <= WIN_DEF;
            x_q          <= '0;
            y_q          <= '0;
            hi_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_idx_q    <= arg_idx_d;
            arg_lo_q     <= arg_lo_d;
            win_q        <= win_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            pix_valid_q  <= pix_valid_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Command FSM: every command byte aborts any partial argument or pixel.
    always_comb begin
        state_d      = state_q;
        arg_idx_d    = arg_idx_q;
        arg_lo_d     = arg_lo_q;
        win_d        = win_q;
        x_d          = x_q;
        y_d          = y_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        pix_valid_d  = 1'b0;
        pix_d        = pix_q;
        frame_done_d = 1'b0;

        if (byte_vld) begin
            if (!rx_dc) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = rx_byte;
                arg_idx_d   = 2'd0;
                case (rx_byte)
                    CMD_CASET:   state_d = ST_ARG_CASET;
                    CMD_RASET:   state_d = ST_ARG_RASET;
                    CMD_RAMWR: begin
                        x_d     = win_q.xs;
                        y_d     = win_q.ys;
                        state_d = ST_RAMWR_HI;
                    end
                    CMD_SWRESET: begin
                        win_d   = WIN_DEF;
                        state_d = ST_IDLE;
                    end
                    default:     state_d = ST_IGNORE;
                endcase
            end else begin
                case (state_q)
                    ST_ARG_CASET, ST_ARG_RASET: begin
                        arg_idx_d = arg_idx_q + 2'd1;
                        if (arg_idx_q == 2'd1) begin
                            arg_lo_d = rx_byte;
                        end
                        if (arg_idx_q == 2'd3) begin
                            if (state_q == ST_ARG_CASET) begin
                                win_d.xs = arg_lo_q;
                                win_d.xe = clamp_end(arg_lo_q, rx_byte);
                            end else begin
                                win_d.ys = arg_lo_q;
                                win_d.ye = clamp_end(arg_lo_q, rx_byte);
                            end
                            state_d = ST_IDLE;
                        end
                    end
                    ST_RAMWR_HI: begin
                        hi_d    = rx_byte;
                        state_d = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        state_d = ST_RAMWR_HI;
                        if ((x_q < X_LIM) && (y_q < Y_LIM)) begin
                            pix_valid_d = 1'b1;
                            pix_d       = '{x: x_q, y: y_q, rgb: {hi_q, rx_byte}};
                        end
                        frame_done_d = (x_q == win_q.xe) && (y_q == win_q.ye);
                        if (x_q == win_q.xe) begin
                            x_d = win_q.xs;
                            y_d = (y_q == win_q.ye) ? win_q.ys : y_q + COORD_W'(1);
                        end else begin
                            x_d = x_q + COORD_W'(1);
                        end
                    end
                    default: state_d = ST_IGNORE;
                endcase
            end
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_q.x;
    assign bus.pix_y      = pix_q.y;
    assign bus.pix_data   = pix_q.rgb;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_spi_rx_decoder.sv
// Directed bench for lcd_spi_rx_decoder: SPI link driven at clk/8, MSB first.
module tb_lcd_spi_rx_decoder;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_spi_rx_decoder_if bus();

    lcd_spi_rx_decoder #(.LCD_W(132), .LCD_H(162)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    // Captured events: {pix_valid, frame_done, x, y, data}
    logic [33:0] ev_q[$];
    logic [7:0]  cmd_q[$];

    // Record every pixel/frame pulse and command pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.pix_valid || bus.frame_done)
            ev_q.push_back({bus.pix_valid, bus.frame_done, bus.pix_x, bus.pix_y, bus.pix_data});
        if (bus.cmd_valid)
            cmd_q.push_back(bus.cmd_code);
    end

    // Shift nbits of b out MSB first; lat = negedges from last sclk rise to first output pulse.
    task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.lcd_data_in = b[7-i];
            bus.lcd_dc_in   = dc;
            repeat (4) @(negedge clk);
            bus.lcd_clk_in = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (lat == 0 && (bus.cmd_valid || bus.pix_valid)) lat = k;
            end
            bus.lcd_clk_in = 1'b0;
        end
        for (int k = 5; k <= 8; k++) begin
            @(negedge clk);
            if (lat == 0 && (bus.cmd_valid || bus.pix_valid)) lat = k;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic cs_low();
        bus.lcd_cs_n_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        bus.lcd_cs_n_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.lcd_rst_n_in = 1'b1;
        bus.lcd_cs_n_in  = 1'b1;
        bus.lcd_clk_in   = 1'b0;
        bus.lcd_data_in  = 1'b0;
        bus.lcd_dc_in    = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %b want 0", bus.cmd_valid); end
        n_checks++; if (bus.cmd_code !== 8'h00) begin n_fail++; $display("FAIL rst_cmd_code: got %h want 00", bus.cmd_code); end
        n_checks++; if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid: got %b want 0", bus.pix_valid); end
        n_checks++; if (bus.pix_x !== 8'd0) begin n_fail++; $display("FAIL rst_pix_x: got %0d want 0", bus.pix_x); end
        n_checks++; if (bus.pix_y !== 8'd0) begin n_fail++; $display("FAIL rst_pix_y: got %0d want 0", bus.pix_y); end
        n_checks++; if (bus.pix_data !== 16'h0000) begin n_fail++; $display("FAIL rst_pix_data: got %h want 0000", bus.pix_data); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", bus.frame_done); end
    endtask

    task automatic test_window_pixels();
        logic [33:0] want [4];
        logic [33:0] got;
        want = '{{1'b1, 1'b0, 8'd5, 8'd10, 16'hF800}, {1'b1, 1'b0, 8'd6, 8'd10, 16'h07E0},
                 {1'b1, 1'b0, 8'd7, 8'd10, 16'h001F}, {1'b1, 1'b0, 8'd5, 8'd11, 16'hFFFF}};
        ev_q.delete(); cmd_q.delete();
        cs_low();
        send_cmd(8'h2A);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL t1_cmd_latency: got %0d want 5", lat); end
        send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h07);
        send_cmd(8'h2B);
        send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h0B);
        send_cmd(8'h2C);
        send_data(8'hF8); send_data(8'h00); send_data(8'h07); send_data(8'hE0);
        send_data(8'h00); send_data(8'h1F); send_data(8'hFF); send_data(8'hFF);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL t1_pix_latency: got %0d want 5", lat); end
        n_checks++;
        if (cmd_q.size() != 3 || cmd_q[0] !== 8'h2A || cmd_q[1] !== 8'h2B || cmd_q[2] !== 8'h2C) begin
            n_fail++; $display("FAIL t1_cmds: got %0d cmds, want 3 (2A 2B 2C)", cmd_q.size());
        end
        n_checks++; if (bus.cmd_code !== 8'h2C) begin n_fail++; $display("FAIL t1_cmd_code: got %h want 2C", bus.cmd_code); end
        n_checks++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL t1_count: got %0d events want 4", ev_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : '0;
            n_checks++;
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL t1_ev%0d: got pv=%b fd=%b (%0d,%0d) %h, want pv=%b fd=%b (%0d,%0d) %h", i,
                         got[33], got[32], got[31:24], got[23:16], got[15:0],
                         want[i][33], want[i][32], want[i][31:24], want[i][23:16], want[i][15:0]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        logic [33:0] want [3];
        logic [33:0] got;
        want = '{{1'b1, 1'b0, 8'd6, 8'd11, 16'hAABB}, {1'b1, 1'b1, 8'd7, 8'd11, 16'hCCDD},
                 {1'b1, 1'b0, 8'd5, 8'd10, 16'hEEFF}};
        ev_q.delete();
        send_data(8'hAA); send_data(8'hBB); send_data(8'hCC);
        send_data(8'hDD); send_data(8'hEE); send_data(8'hFF);
        n_checks++; if (ev_q.size() != 3) begin n_fail++; $display("FAIL t2_count: got %0d events want 3", ev_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : '0;
            n_checks++;
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL t2_ev%0d: got pv=%b fd=%b (%0d,%0d) %h, want pv=%b fd=%b (%0d,%0d) %h", i,
                         got[33], got[32], got[31:24], got[23:16], got[15:0],
                         want[i][33], want[i][32], want[i][31:24], want[i][23:16], want[i][15:0]);
            end
        end
    endtask

    task automatic test_edge_clip();
        logic [33:0] want [5];
        logic [33:0] got;
        want = '{{1'b1, 1'b0, 8'd128, 8'd0, 16'h1000}, {1'b1, 1'b0, 8'd129, 8'd0, 16'h1001},
                 {1'b1, 1'b0, 8'd130, 8'd0, 16'h1002}, {1'b1, 1'b0, 8'd131, 8'd0, 16'h1003},
                 {1'b0, 1'b1, 8'd131, 8'd0, 16'h1003}};
        ev_q.delete();
        send_cmd(8'h2A); send_data(8'h00); send_data(8'h80); send_data(8'h00); send_data(8'h85);
        send_cmd(8'h2B); send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_cmd(8'h2C);
        for (int p = 0; p < 6; p++) begin
            send_data(8'h10);
            send_data(8'(p));
        end
        n_checks++; if (ev_q.size() != 5) begin n_fail++; $display("FAIL t3_count: got %0d events want 5", ev_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : '0;
            n_checks++;
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL t3_ev%0d: got pv=%b fd=%b (%0d,%0d) %h, want pv=%b fd=%b (%0d,%0d) %h", i,
                         got[33], got[32], got[31:24], got[23:16], got[15:0],
                         want[i][33], want[i][32], want[i][31:24], want[i][23:16], want[i][15:0]);
            end
        end
    endtask

    task automatic test_cs_abort();
        logic [33:0] got;
        send_bits(1'b1, 8'hFF, 5);
        cs_high();
        cs_low();
        ev_q.delete();
        send_data(8'hAB);
        n_checks++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL t4_no_pix: got %0d events want 0", ev_q.size()); end
        send_data(8'hCD);
        got = (ev_q.size() > 0) ? ev_q[0] : '0;
        n_checks++;
        if (ev_q.size() != 1 || got !== {1'b1, 1'b0, 8'd128, 8'd0, 16'hABCD}) begin
            n_fail++;
            $display("FAIL t4_pix: got %0d events, first pv=%b fd=%b (%0d,%0d) %h, want 1 event pv=1 fd=0 (128,0) abcd",
                     ev_q.size(), got[33], got[32], got[31:24], got[23:16], got[15:0]);
        end
    endtask

    task automatic test_cmd_abort_pixel();
        logic [33:0] got;
        ev_q.delete(); cmd_q.delete();
        send_cmd(8'h2C);
        send_data(8'h12);
        send_cmd(8'h2C);
        send_data(8'h34);
        send_data(8'h56);
        n_checks++;
        if (cmd_q.size() != 2 || cmd_q[0] !== 8'h2C || cmd_q[1] !== 8'h2C) begin
            n_fail++; $display("FAIL t5_cmds: got %0d cmds, want 2 (2C 2C)", cmd_q.size());
        end
        got = (ev_q.size() > 0) ? ev_q[0] : '0;
        n_checks++;
        if (ev_q.size() != 1 || got !== {1'b1, 1'b0, 8'd128, 8'd0, 16'h3456}) begin
            n_fail++;
            $display("FAIL t5_pix: got %0d events, first pv=%b fd=%b (%0d,%0d) %h, want 1 event pv=1 fd=0 (128,0) 3456",
                     ev_q.size(), got[33], got[32], got[31:24], got[23:16], got[15:0]);
        end
    endtask

    task automatic test_clamp_swreset();
        logic [33:0] want [4];
        logic [33:0] got;
        want = '{{1'b1, 1'b1, 8'd9, 8'd2, 16'h1111}, {1'b1, 1'b1, 8'd9, 8'd2, 16'h2222},
                 {1'b1, 1'b0, 8'd0, 8'd0, 16'h3333}, {1'b1, 1'b0, 8'd1, 8'd0, 16'h4444}};
        ev_q.delete();
        send_cmd(8'h2A); send_data(8'h00); send_data(8'h09); send_data(8'h00); send_data(8'h03);
        send_cmd(8'h2B); send_data(8'h00); send_data(8'h02); send_data(8'h00); send_data(8'h01);
        send_cmd(8'h2C);
        send_data(8'h11); send_data(8'h11); send_data(8'h22); send_data(8'h22);
        send_cmd(8'h01);
        send_cmd(8'h2C);
        send_data(8'h33); send_data(8'h33); send_data(8'h44); send_data(8'h44);
        n_checks++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL t7_count: got %0d events want 4", ev_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : '0;
            n_checks++;
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL t7_ev%0d: got pv=%b fd=%b (%0d,%0d) %h, want pv=%b fd=%b (%0d,%0d) %h", i,
                         got[33], got[32], got[31:24], got[23:16], got[15:0],
                         want[i][33], want[i][32], want[i][31:24], want[i][23:16], want[i][15:0]);
            end
        end
    endtask

    task automatic test_link_reset();
        logic [33:0] want [2];
        logic [33:0] got;
        want = '{{1'b1, 1'b0, 8'd0, 8'd0, 16'h1234}, {1'b1, 1'b0, 8'd1, 8'd0, 16'h5678}};
        send_cmd(8'h2A); send_data(8'h00); send_data(8'h03); send_data(8'h00); send_data(8'h04);
        send_cmd(8'h2C);
        send_data(8'h77);
        bus.lcd_rst_n_in = 1'b0;
        repeat (4) @(negedge clk);
        bus.lcd_rst_n_in = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.cmd_code !== 8'h00) begin n_fail++; $display("FAIL t6_cmd_code: got %h want 00", bus.cmd_code); end
        n_checks++; if (bus.pix_x !== 8'd0) begin n_fail++; $display("FAIL t6_pix_x: got %0d want 0", bus.pix_x); end
        n_checks++; if (bus.pix_data !== 16'h0000) begin n_fail++; $display("FAIL t6_pix_data: got %h want 0000", bus.pix_data); end
        ev_q.delete();
        send_cmd(8'h2C);
        send_data(8'h12); send_data(8'h34); send_data(8'h56); send_data(8'h78);
        n_checks++; if (ev_q.size() != 2) begin n_fail++; $display("FAIL t6_count: got %0d events want 2", ev_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < ev_q.size()) ? ev_q[i] : '0;
            n_checks++;
            if (got !== want[i]) begin
                n_fail++;
                $display("FAIL t6_ev%0d: got pv=%b fd=%b (%0d,%0d) %h, want pv=%b fd=%b (%0d,%0d) %h", i,
                         got[33], got[32], got[31:24], got[23:16], got[15:0],
                         want[i][33], want[i][32], want[i][31:24], want[i][23:16], want[i][15:0]);
            end
        end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_window_pixels();
        test_frame_wrap();
        test_edge_clip();
        test_cs_abort();
        test_cmd_abort_pixel();
        test_clamp_swreset();
        test_link_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
